bus_stim_gen: RTL and testbench

BUS_STIM_GEN -- requirements
Module: bus_stim_gen

---
 rtl/bus_stim_pkg.sv | 23 ++
 rtl/bus_stim_gen_if.sv | 15 +
 rtl/bus_stim_lfsr.sv | 30 +++
 rtl/bus_stim_gen.sv | 160 ++++++++++++++++
 tb/tb_bus_stim_gen.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_stim_pkg.sv
// Shared types for the bus stimulus generator: FSM states, address mode and
// Galois LFSR feedback masks (maximal length) indexed by address width.
package bus_stim_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        MODE_INC  = 1'b0,
        MODE_LFSR = 1'b1
    } mode_e;

    // Right-shifting Galois form: v' = (v >> 1) ^ (v[0] ? mask : 0)
    localparam logic [15:0] LFSR_TAPS [3:16] = '{
        16'h0006, 16'h000C, 16'h0014, 16'h0030, 16'h0060, 16'h00B8, 16'h0110,
        16'h0240, 16'h0500, 16'h0E08, 16'h1C80, 16'h3802, 16'h6000, 16'hB400
    };

endpackage

// File: rtl/bus_stim_gen_if.sv
// Beat bus between the stimulus generator (master) and its sink (slave).
// ready is the only signal flowing back towards the generator.
interface bus_stim_gen_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic              en;
    logic [DATA_W-1:0] wdata;
    logic              ready;

    modport master (output addr, output wr, output en, output wdata, input ready);
    modport slave  (input addr, input wr, input en, input wdata, output ready);
endinterface

// File: rtl/bus_stim_lfsr.sv
// Galois LFSR address source; value runs one step ahead of the beat on the bus.
// Latency 1 from load/step; no backpressure of its own, step only on accepted beats.
module bus_stim_lfsr
    import bus_stim_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] seed,
    input  logic              step,
    output logic [ADDR_W-1:0] value
);
    localparam logic [ADDR_W-1:0] MASK = ADDR_W'(LFSR_TAPS[ADDR_W]);

    function automatic logic [ADDR_W-1:0] advance(input logic [ADDR_W-1:0] v);
        return (v >> 1) ^ (v[0] ? MASK : '0);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= advance(seed);
        end else if (step) begin
            value <= advance(value);
        end
    end
endmodule

// File: rtl/bus_stim_gen.sv
// Write-then-read beat sequencer; LFSR addressing only with BUS_STIM_GEN_LFSR_EN.
// First beat 1 cycle after start; ready=0 freezes the current beat in place.
module bus_stim_gen
    import bus_stim_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  wr_len,
    input  logic [LEN_W-1:0]  rd_len,
    output logic              busy,
    output logic              done,
    bus_stim_gen_if.master    bus
);
    state_e            state, state_nxt;
    logic [ADDR_W-1:0] base_q, src_base, first_addr, next_addr, addr_nxt;
    logic [LEN_W-1:0]  wr_len_q, rd_len_q, cnt, cnt_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic              wr_nxt, en_nxt, busy_nxt, done_nxt;
    logic              accept, wr_last, rd_last, phase_start;

    assign accept   = bus.en && bus.ready;
    assign wr_last  = (cnt == wr_len_q - LEN_W'(1));
    assign rd_last  = (cnt == rd_len_q - LEN_W'(1));
    // From IDLE the live inputs describe the phase; afterwards the captured copy does
    assign src_base = (state == IDLE) ? base_addr : base_q;
    assign phase_start = (state_nxt != state) && ((state_nxt == WRITE) || (state_nxt == READ));

`ifdef BUS_STIM_GEN_LFSR_EN
    mode_e             mode_q;
    logic              use_lfsr;
    logic [ADDR_W-1:0] seed_eff, lfsr_value;

    assign use_lfsr   = ((state == IDLE) ? mode_e'(mode) : mode_q) == MODE_LFSR;
    assign seed_eff   = (src_base == '0) ? '1 : src_base;
    assign first_addr = use_lfsr ? seed_eff : src_base;
    assign next_addr  = use_lfsr ? lfsr_value : bus.addr + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q <= MODE_INC;
        end else if (state == IDLE && start) begin
            mode_q <= mode_e'(mode);
        end
    end

    bus_stim_lfsr #(.ADDR_W(ADDR_W)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (phase_start),
        .seed  (seed_eff),
        .step  (accept),
        .value (lfsr_value)
    );
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign first_addr  = src_base;
    assign next_addr   = bus.addr + ADDR_W'(1);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (wr_len != '0)      state_nxt = WRITE;
                    else if (rd_len != '0) state_nxt = READ;
                    else                   state_nxt = DONE;
                end
            end
            WRITE: begin
                if (accept && wr_last) state_nxt = (rd_len_q != '0) ? READ : DONE;
            end
            READ: begin
                if (accept && rd_last) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered bus outputs, keyed on the state being entered
    always_comb begin
        addr_nxt  = bus.addr;
        wr_nxt    = bus.wr;
        en_nxt    = bus.en;
        wdata_nxt = bus.wdata;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        cnt_nxt   = cnt;
        unique case (state_nxt)
            WRITE, READ: begin
                en_nxt   = 1'b1;
                wr_nxt   = (state_nxt == WRITE);
                busy_nxt = 1'b1;
                if (phase_start) begin
                    cnt_nxt   = '0;
                    addr_nxt  = first_addr;
                    wdata_nxt = '0;
                end else if (accept) begin
                    cnt_nxt   = cnt + LEN_W'(1);
                    addr_nxt  = next_addr;
                    wdata_nxt = wr_nxt ? DATA_W'(cnt + LEN_W'(1)) : '0;
                end
            end
            DONE: begin
                addr_nxt  = '0;
                wr_nxt    = 1'b0;
                en_nxt    = 1'b0;
                wdata_nxt = '0;
                done_nxt  = 1'b1;
            end
            default: begin
                addr_nxt  = '0;
                wr_nxt    = 1'b0;
                en_nxt    = 1'b0;
                wdata_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q    <= '0;
            wr_len_q  <= '0;
            rd_len_q  <= '0;
            cnt       <= '0;
            bus.addr  <= '0;
            bus.wr    <= 1'b0;
            bus.en    <= 1'b0;
            bus.wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                base_q   <= base_addr;
                wr_len_q <= wr_len;
                rd_len_q <= rd_len;
            end
            cnt       <= cnt_nxt;
            bus.addr  <= addr_nxt;
            bus.wr    <= wr_nxt;
            bus.en    <= en_nxt;
            bus.wdata <= wdata_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end
endmodule

// File: tb/tb_bus_stim_gen.sv
// Randomised bench for bus_stim_gen against a beat-list reference model.
module tb_bus_stim_gen;
    localparam int AW = 6;
    localparam int DW = 8;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_n, start, mode, busy, done;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] wr_len, rd_len;

    int n_chk = 0;
    int n_bad = 0;
    int got_addr[$];
    int got_wr[$];
    int got_wd[$];

    always #5 clk = ~clk;

    bus_stim_gen_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

    bus_stim_gen #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .base_addr (base_addr),
        .wr_len    (wr_len),
        .rd_len    (rd_len),
        .busy      (busy),
        .done      (done),
        .bus       (bus_if)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_addr"}, bus_if.addr, 0);
        chk({tag, "_wr"}, bus_if.wr, 0);
        chk({tag, "_en"}, bus_if.en, 0);
        chk({tag, "_wdata"}, bus_if.wdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // Incrementing model: write beat k -> (base+k, k), read beat k -> (base+k, 0)
    task automatic cmp_inc(input int b, input int wl, input int rl);
        chk("beat_count", got_addr.size(), wl + rl);
        for (int k = 0; k < wl + rl && k < got_addr.size(); k++) begin
            bit is_w;
            int idx;
            is_w = (k < wl);
            idx  = is_w ? k : k - wl;
            chk($sformatf("wr[%0d]", k), got_wr[k], is_w);
            chk($sformatf("addr[%0d]", k), got_addr[k], (b + idx) % (1 << AW));
            chk($sformatf("wdata[%0d]", k), got_wd[k], is_w ? idx % (1 << DW) : 0);
        end
    endtask

`ifdef BUS_STIM_GEN_LFSR_EN
    task automatic cmp_lfsr(input int b, input int wl, input int rl);
        int dup, zero;
        dup  = 0;
        zero = 0;
        chk("beat_count", got_addr.size(), wl + rl);
        if (got_addr.size() == wl + rl) begin
            if (wl > 0) chk("lfsr_seed", got_addr[0], (b == 0) ? (1 << AW) - 1 : b);
            for (int i = 0; i < wl; i++) begin
                if (got_addr[i] == 0) zero++;
                for (int j = 0; j < i; j++) if (got_addr[i] == got_addr[j]) dup++;
                chk($sformatf("lfsr_wr[%0d]", i), got_wr[i], 1);
                chk($sformatf("lfsr_wdata[%0d]", i), got_wd[i], i);
            end
            chk("lfsr_distinct", dup, 0);
            chk("lfsr_nonzero", zero, 0);
            for (int k = 0; k < rl; k++) begin
                chk($sformatf("lfsr_rd_wr[%0d]", k), got_wr[wl + k], 0);
                chk($sformatf("lfsr_replay[%0d]", k), got_addr[wl + k], got_addr[k]);
            end
        end
    endtask
`endif

    task automatic run_seq(input int m, input int b, input int wl, input int rl,
                           input int stall_beat, input int stall_len, input bit rnd_ready);
        int  budget, nb, stalled, stall_tot;
        int  p_addr, p_wr, p_en, p_wd, p_rdy;
        bit  seen_done;
        got_addr.delete();
        got_wr.delete();
        got_wd.delete();
        start     = 1'b1;
        mode      = m[0];
        base_addr = AW'(b);
        wr_len    = LW'(wl);
        rd_len    = LW'(rl);
        tick();
        budget    = 4 * (wl + rl) + stall_len + 20;
        nb        = 0;
        stalled   = 0;
        stall_tot = 0;
        seen_done = 1'b0;
        p_rdy     = 1;
        p_en      = 0;
        p_addr    = 0;
        p_wr      = 0;
        p_wd      = 0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            if (cyc == 1) begin
                chk("first_en", bus_if.en, (wl + rl) > 0);
                chk("first_busy", busy, (wl + rl) > 0);
            end
            if (p_rdy == 0 && p_en == 1) begin
                chk("hold_addr", bus_if.addr, p_addr);
                chk("hold_wr", bus_if.wr, p_wr);
                chk("hold_en", bus_if.en, p_en);
                chk("hold_wdata", bus_if.wdata, p_wd);
            end
            if (done) begin
                chk("done_busy", busy, 0);
                chk("done_en", bus_if.en, 0);
                chk("done_cycle", cyc, wl + rl + stall_tot + 1);
                seen_done = 1'b1;
            end
            if (bus_if.en && nb == stall_beat && stalled < stall_len) begin
                bus_if.ready = 1'b0;
                stalled++;
            end else if (rnd_ready) begin
                bus_if.ready = ($urandom_range(0, 3) != 0);
            end else begin
                bus_if.ready = 1'b1;
            end
            if (bus_if.en && bus_if.ready) begin
                got_addr.push_back(int'(bus_if.addr));
                got_wr.push_back(int'(bus_if.wr));
                got_wd.push_back(int'(bus_if.wdata));
                nb++;
            end else if (bus_if.en) begin
                stall_tot++;
            end
            // Spurious start while the sequence owns the FSM must be ignored
            start = (cyc == 1);
            if (cyc == 1) begin
                mode      = $urandom_range(0, 1);
                base_addr = AW'($urandom_range(0, (1 << AW) - 1));
                wr_len    = LW'($urandom_range(1, 5));
                rd_len    = LW'($urandom_range(1, 5));
            end
            p_addr = int'(bus_if.addr);
            p_wr   = int'(bus_if.wr);
            p_en   = int'(bus_if.en);
            p_wd   = int'(bus_if.wdata);
            p_rdy  = int'(bus_if.ready);
            if (seen_done) break;
            tick();
        end
        if (!seen_done) chk("done_timeout", 0, 1);
        tick();
        start        = 1'b0;
        bus_if.ready = 1'b1;
        chk_quiet("idle1");
        tick();
        chk_quiet("idle2");
`ifdef BUS_STIM_GEN_LFSR_EN
        if (m != 0) cmp_lfsr(b, wl, rl);
        else        cmp_inc(b, wl, rl);
`else
        cmp_inc(b, wl, rl);
`endif
    endtask

    initial begin
        int rd_seen;
        rst_n        = 1'b0;
        start        = 1'b0;
        mode         = 1'b0;
        base_addr    = '0;
        wr_len       = '0;
        rd_len       = '0;
        bus_if.ready = 1'b1;
        repeat (3) tick();
        chk_quiet("reset");
        rst_n = 1'b1;
        tick();

        run_seq(0, 5, 1, 1, -1, 0, 1'b0);
        run_seq(0, 62, 4, 0, -1, 0, 1'b0);
        run_seq(0, 20, 5, 2, 2, 3, 1'b0);
        run_seq(1, 0, 8, 8, -1, 0, 1'b0);
        run_seq(0, 33, 0, 0, -1, 0, 1'b0);

        // Reset while read beat 1 is on the bus
        start     = 1'b1;
        mode      = 1'b0;
        base_addr = AW'(10);
        wr_len    = LW'(3);
        rd_len    = LW'(3);
        tick();
        start   = 1'b0;
        rd_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus_if.en && !bus_if.wr) rd_seen++;
            if (rd_seen == 2) break;
            tick();
        end
        chk("rst_reached_rd1", rd_seen, 2);
        rst_n = 1'b0;
        tick();
        chk_quiet("midrst");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrst_no_done", done, 0);
            chk("midrst_no_en", bus_if.en, 0);
        end
        run_seq(0, 40, 2, 3, -1, 0, 1'b0);

        for (int t = 0; t < 25; t++) begin
            int m, b, wl, rl;
            m  = $urandom_range(0, 1);
            b  = $urandom_range(0, (1 << AW) - 1);
            wl = $urandom_range(0, 12);
            rl = $urandom_range(0, 12);
`ifdef BUS_STIM_GEN_LFSR_EN
            if (m != 0 && rl > wl) rl = wl;
`endif
            run_seq(m, b, wl, rl, $urandom_range(0, 6), $urandom_range(0, 3), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
